bit_serializer: RTL and testbench

//  Parallel-to-serial front end for the sequence-detector path.

---
 rtl/bit_serializer.sv | 123 ++++++++++++
 tb/tb_bit_serializer.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready handshake
// and shifts them out one bit per enabled clock, with a one-word holding buffer.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy,
  output logic             state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Handshake: a word moves on any rising edge where in_valid & in_ready.
  // in_ready depends only on registered state, never on in_valid.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             transfer;
  logic             is_shift;
  logic             last;
  logic [WIDTH-1:0] sreg_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    transfer    = in_valid & ~hold_full_q;
    is_shift    = (state_q == SHIFT);
    // Out-of-range count codes are folded into "last" so the word always ends.
    last        = is_shift & en & (cnt_q >= CNT_LAST);
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end

    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          cnt_d = '0;
          if (hold_full_q) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
          end else if (transfer) begin
            sreg_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (en) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
          end
          if (transfer) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        hold_full_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready     = ~hold_full_q;
    serial_valid = is_shift;
    word_done    = last;
    busy         = is_shift | hold_full_q;
    state_dbg    = is_shift;
    if (is_shift) begin
      serial_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end else begin
      serial_out = IDLE_LEVEL;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: directed scenarios plus randomized traffic, with an
// always-on word-queue scoreboard on the MSB-first instance.
module tb_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       en;
  logic       serial_out;
  logic       serial_valid;
  logic       word_done;
  logic       busy;
  logic       state_dbg;

  logic [7:0] l_in_data;
  logic       l_in_valid;
  logic       l_in_ready;
  logic       l_en;
  logic       l_serial_out;
  logic       l_serial_valid;
  logic       l_word_done;
  logic       l_busy;
  logic       l_state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         bit_idx = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .serial_out(serial_out),
    .serial_valid(serial_valid), .word_done(word_done), .busy(busy),
    .state_dbg(state_dbg)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(l_in_data), .in_valid(l_in_valid),
    .in_ready(l_in_ready), .en(l_en), .serial_out(l_serial_out),
    .serial_valid(l_serial_valid), .word_done(l_word_done), .busy(l_busy),
    .state_dbg(l_state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: accepted words wait in exp_q; each enabled edge with a word in
  // flight consumes the next bit, MSB first. The front word is on the wire, a
  // second one sits in the buffer.
  always @(negedge clk) begin
    logic [7:0] w;
    logic       exp_bit;
    logic       exp_done;
    if (!rst_n) begin
      exp_q.delete();
      bit_idx = 0;
    end else begin
      exp_done = 1'b0;
      checks++;
      if (serial_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_serial_valid got %b exp %b", serial_valid, exp_q.size() != 0);
      end
      checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        errors++;
        $display("FAIL sb_in_ready got %b exp %b", in_ready, exp_q.size() < 2);
      end
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_busy got %b exp %b", busy, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        w = exp_q[0];
        exp_bit = w[7 - bit_idx];
        checks++;
        if (serial_out !== exp_bit) begin
          errors++;
          $display("FAIL sb_serial_out word %h bit %0d got %b exp %b", w, bit_idx, serial_out, exp_bit);
        end
        if (en) begin
          bit_idx++;
          if (bit_idx == 8) begin
            void'(exp_q.pop_front());
            bit_idx = 0;
            exp_done = 1'b1;
          end
        end
      end else begin
        checks++;
        if (serial_out !== 1'b0) begin
          errors++;
          $display("FAIL sb_idle_level got %b exp 0", serial_out);
        end
      end
      checks++;
      if (word_done !== exp_done) begin
        errors++;
        $display("FAIL sb_word_done got %b exp %b", word_done, exp_done);
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // driver: present one word and hold it until accepted
  task automatic send_word(input logic [7:0] w);
    bit acc = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout word %h got not_accepted exp accepted", w);
    end
  endtask

  // monitor: record consumed bits and handshake activity for ncyc cycles
  task automatic capture(input int ncyc, output logic [63:0] bits, output int nbits,
                         output int done_cnt, output int max_run, output bit saw_stall);
    int run = 0;
    bits = '0; nbits = 0; done_cnt = 0; max_run = 0; saw_stall = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (serial_valid && en) begin
        bits = {bits[62:0], serial_out};
        nbits++;
      end
      if (word_done) done_cnt++;
      if (!in_ready) saw_stall = 1'b1;
      if (serial_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = '0; in_valid = 1'b0; en = 1'b0;
    l_in_data = '0; l_in_valid = 1'b0; l_en = 1'b0;
    #2;
    checks++;
    if ({serial_out, serial_valid, in_ready, word_done, busy, state_dbg} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 001000",
               {serial_out, serial_valid, in_ready, word_done, busy, state_dbg});
    end
    checks++;
    if ({l_serial_out, l_serial_valid, l_in_ready, l_word_done, l_busy} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_outputs_lsb got %b exp 10100",
               {l_serial_out, l_serial_valid, l_in_ready, l_word_done, l_busy});
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hA5;
    en = 1'b1;
    in_data = w; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== w[8-k] || serial_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_bit cycle %0d got %b/%b exp %b/1", k, serial_out, serial_valid, w[8-k]);
      end
      checks++;
      if (word_done !== (k == 8)) begin
        errors++;
        $display("FAIL single_word_done cycle %0d got %b exp %b", k, word_done, k == 8);
      end
    end
    @(negedge clk);
    checks++;
    if ({serial_out, serial_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_after got %b exp 000", {serial_out, serial_valid, busy});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] bits;
    int nbits, done_cnt, max_run;
    bit saw_stall;
    en = 1'b1;
    fork
      begin
        send_word(8'h92);
        send_word(8'h49);
        send_word(8'hFF);
        in_valid = 1'b0;
      end
      capture(40, bits, nbits, done_cnt, max_run, saw_stall);
    join
    checks++;
    if (nbits != 24 || bits[23:0] !== 24'b10010010_01001001_11111111) begin
      errors++;
      $display("FAIL b2b_stream got %0d bits %b exp 24 bits 100100100100100111111111", nbits, bits[23:0]);
    end
    checks++;
    if (done_cnt != 3) begin
      errors++;
      $display("FAIL b2b_word_done got %0d exp 3", done_cnt);
    end
    checks++;
    if (max_run != 24) begin
      errors++;
      $display("FAIL b2b_valid_run got %0d exp 24", max_run);
    end
    checks++;
    if (saw_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_drop got %b exp 1", saw_stall);
    end
  endtask

  task automatic test_slow_enable();
    int valid_cycles = 0;
    int done_cnt = 0;
    int done_k = 0;
    en = 1'b0;
    in_data = 8'h3C; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      en = (k % 3 == 0);
      @(negedge clk);
      if (serial_valid) valid_cycles++;
      if (word_done) begin
        done_cnt++;
        done_k = k;
      end
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    checks++;
    if (valid_cycles != 24) begin
      errors++;
      $display("FAIL slow_valid_cycles got %0d exp 24", valid_cycles);
    end
    checks++;
    if (done_cnt != 1 || done_k != 24) begin
      errors++;
      $display("FAIL slow_word_done got count %0d at %0d exp count 1 at 24", done_cnt, done_k);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] words[2];
    words[0] = 8'h01;
    words[1] = 8'($urandom);
    l_en = 1'b1;
    checks++;
    if (l_serial_out !== 1'b1 || l_serial_valid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_idle got %b/%b exp 1/0", l_serial_out, l_serial_valid);
    end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] w = words[i];
      l_in_data = w; l_in_valid = 1'b1;
      @(posedge clk);
      #1 l_in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        checks++;
        if (l_serial_out !== w[k-1] || l_serial_valid !== 1'b1 || l_word_done !== (k == 8)) begin
          errors++;
          $display("FAIL lsb_bit word %h cycle %0d got %b/%b/%b exp %b/1/%b",
                   w, k, l_serial_out, l_serial_valid, l_word_done, w[k-1], k == 8);
        end
      end
      @(negedge clk);
      checks++;
      if (l_serial_out !== 1'b1 || l_serial_valid !== 1'b0) begin
        errors++;
        $display("FAIL lsb_after got %b/%b exp 1/0", l_serial_out, l_serial_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_midword_reset();
    en = 1'b1;
    in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h5A;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || serial_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_setup got ready %b busy %b bit %b exp 0 1 0", in_ready, busy, serial_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({serial_out, serial_valid, in_ready, word_done, busy, state_dbg} !== 6'b001000) begin
      errors++;
      $display("FAIL rst_midword got %b exp 001000",
               {serial_out, serial_valid, in_ready, word_done, busy, state_dbg});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (serial_valid !== 1'b0 || serial_out !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_resume cycle %0d got %b%b%b exp 000", k, serial_valid, serial_out, busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_detector();
    logic [63:0] bits;
    int nbits, done_cnt, max_run;
    bit saw_stall;
    logic [4:0] win = '0;
    int hits[$];
    int exp_hits[3] = '{4, 7, 10};
    en = 1'b1;
    fork
      begin
        send_word(8'h92);
        send_word(8'h40);
        in_valid = 1'b0;
      end
      capture(30, bits, nbits, done_cnt, max_run, saw_stall);
    join
    for (int i = 0; i < nbits; i++) begin
      win = {win[3:0], bits[nbits-1-i]};
      if (i >= 4 && win == 5'b10010) hits.push_back(i);
    end
    checks++;
    if (nbits != 16 || max_run != 16) begin
      errors++;
      $display("FAIL det_stream got %0d bits run %0d exp 16 run 16", nbits, max_run);
    end
    checks++;
    if (hits.size() != 3) begin
      errors++;
      $display("FAIL det_hit_count got %0d exp 3", hits.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hits[i] != exp_hits[i]) begin
          errors++;
          $display("FAIL det_hit_pos %0d got %0d exp %0d", i, hits[i], exp_hits[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int accepted = 0;
    int done_cnt = 0;
    bit acc;
    bit drained = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (word_done) done_cnt++;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted++;
        if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
        else in_data = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    en = 1'b1;
    for (int t = 0; t < 40 && !drained; t++) begin
      @(negedge clk);
      if (word_done) done_cnt++;
      if (!busy) drained = 1'b1;
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL rand_drain got busy exp idle");
    end
    checks++;
    if (done_cnt != accepted) begin
      errors++;
      $display("FAIL rand_word_count got %0d done exp %0d", done_cnt, accepted);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    test_slow_enable();
    test_lsb_first();
    test_midword_reset();
    test_detector();
    repeat (3) @(posedge clk);
    #1;
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
